cursor_overlay_writer: RTL and testbench

Parametrised successor to the PS/2 mouse display path. Polls the PS/2 mouse register file (status, X, Y) through a shared address/data port and keeps a coherent cursor snapshot. Scans the framebuffer in row-major order, one pixel per `VGA_ready` cycle, and writes a button-coloured square cursor over a background colour. It sits between the PS/2 register file and the VGA framebuffer write port.

---
 rtl/mouse_display_pkg.sv | 33 +++
 rtl/mouse_reg_poller.sv | 78 +++++++
 rtl/cursor_overlay_writer.sv | 162 ++++++++++++++++
 tb/tb_cursor_overlay_writer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mouse_display_pkg.sv
// mouse_display_pkg
//   Shared definitions for the PS/2 mouse display path: register-file
//   addresses, the poll-state enum and the status button bit indices.
package mouse_display_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_X      = 2'd1;
  localparam logic [1:0] REG_Y      = 2'd2;

  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;

  typedef enum logic [1:0] {
    RD_STATUS = 2'd0,
    RD_X      = 2'd1,
    RD_Y      = 2'd2
  } poll_state_t;

  // Register-file address driven while in a given poll state; the unused
  // encoding reads the status register, matching where the FSM recovers to.
  function automatic logic [1:0] poll_addr(input poll_state_t s);
    logic [1:0] a;
    a = REG_STATUS;
    case (s)
      RD_STATUS: a = REG_STATUS;
      RD_X:      a = REG_X;
      RD_Y:      a = REG_Y;
      default:   a = REG_STATUS;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mouse_reg_poller.sv
// mouse_reg_poller
//   Round-robin poll of the PS/2 mouse register file (status, X, Y), one
//   register per cycle, publishing a coherent {buttons, x, y} shadow once
//   per 3-cycle poll.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_data         : register-file read data (combinational from o_addr)
//   o_addr         : register-file read address
//   o_buttons      : shadow status button bits {right, left}
//   o_x, o_y       : shadow mouse coordinates
module mouse_reg_poller
  import mouse_display_pkg::*;
#(
  parameter int unsigned LOC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_data,
  output logic [1:0]       o_addr,
  output logic [1:0]       o_buttons,
  output logic [LOC_W-1:0] o_x,
  output logic [LOC_W-1:0] o_y
);

  poll_state_t      r_state;
  poll_state_t      w_state_next;
  logic [1:0]       r_pend_btn;
  logic [LOC_W-1:0] r_pend_x;
  logic [1:0]       r_sh_btn;
  logic [LOC_W-1:0] r_sh_x;
  logic [LOC_W-1:0] r_sh_y;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RD_STATUS;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = RD_STATUS;
    case (r_state)
      RD_STATUS: w_state_next = RD_X;
      RD_X:      w_state_next = RD_Y;
      RD_Y:      w_state_next = RD_STATUS;
      default:   w_state_next = RD_STATUS;
    endcase
  end

  assign o_addr = poll_addr(r_state);

  // Only the button bits of the status register are consumed downstream.
  // Y needs no pending stage: it is the last read of the poll and goes
  // straight into the shadow together with the pending status and X.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_btn <= '0;
      r_pend_x   <= '0;
      r_sh_btn   <= '0;
      r_sh_x     <= '0;
      r_sh_y     <= '0;
    end else begin
      case (r_state)
        RD_STATUS: r_pend_btn <= i_data[1:0];
        RD_X:      r_pend_x   <= i_data[LOC_W-1:0];
        RD_Y: begin
          r_sh_btn <= r_pend_btn;
          r_sh_x   <= r_pend_x;
          r_sh_y   <= i_data[LOC_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign o_buttons = r_sh_btn;
  assign o_x       = r_sh_x;
  assign o_y       = r_sh_y;

endmodule

// File: rtl/cursor_overlay_writer.sv
// cursor_overlay_writer
//   Scans the framebuffer row-major, one pixel per VGA_ready cycle, and
//   writes a button-coloured square cursor over a background colour. The
//   cursor position/buttons are snapshotted only at frame start, so a frame
//   never tears.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   VGA_ready  : framebuffer accepts one write this cycle
//   data       : register-file read data (combinational from addr)
//   addr       : register-file read address
//   wr_en      : framebuffer write strobe (registered)
//   wr_addr    : framebuffer write address (registered)
//   wr_data    : framebuffer pixel colour (registered)
module cursor_overlay_writer
  import mouse_display_pkg::*;
#(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned PIX_W       = 3,
  parameter int unsigned LOC_W       = 8,
  parameter int unsigned LOC_SHIFT   = 1,
  parameter int unsigned CURSOR_SIZE = 4,
  parameter int unsigned COLOR_BG    = 0,
  parameter int unsigned COLOR_IDLE  = 6,
  parameter int unsigned COLOR_LEFT  = 4,
  parameter int unsigned COLOR_RIGHT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              VGA_ready,
  input  logic [7:0]        data,
  output logic [1:0]        addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam int unsigned PX_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned PY_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned CW   = LOC_W + LOC_SHIFT + 1;
  localparam int unsigned HX_W = (CW > PX_W) ? CW : PX_W;
  localparam int unsigned HY_W = (CW > PY_W) ? CW : PY_W;

  logic [1:0]        w_sh_btn;
  logic [LOC_W-1:0]  w_sh_x;
  logic [LOC_W-1:0]  w_sh_y;

  logic [PX_W-1:0]   r_px;
  logic [PY_W-1:0]   r_py;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic [1:0]        r_act_btn;
  logic [LOC_W-1:0]  r_act_x;
  logic [LOC_W-1:0]  r_act_y;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;

  logic              w_frame_start;
  logic              w_line_end;
  logic              w_frame_end;
  logic [1:0]        w_cur_btn;
  logic [LOC_W-1:0]  w_cur_x;
  logic [LOC_W-1:0]  w_cur_y;
  logic [CW-1:0]     w_cx;
  logic [CW-1:0]     w_cy;
  logic [CW-1:0]     w_cx_end;
  logic [CW-1:0]     w_cy_end;
  logic              w_hit;
  logic [PIX_W-1:0]  w_color;

  mouse_reg_poller #(
    .LOC_W (LOC_W)
  ) u_poller (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_data    (data),
    .o_addr    (addr),
    .o_buttons (w_sh_btn),
    .o_x       (w_sh_x),
    .o_y       (w_sh_y)
  );

  assign w_frame_start = VGA_ready && (r_px == '0) && (r_py == '0);
  assign w_line_end    = (r_px == PX_W'(H_RES - 1));
  assign w_frame_end   = w_line_end && (r_py == PY_W'(V_RES - 1));

  // The frame-start pixel is drawn with the snapshot being taken on that
  // same edge, so bypass the active registers for it.
  assign w_cur_btn = w_frame_start ? w_sh_btn : r_act_btn;
  assign w_cur_x   = w_frame_start ? w_sh_x   : r_act_x;
  assign w_cur_y   = w_frame_start ? w_sh_y   : r_act_y;

  // One spare bit above the shifted coordinate keeps cx+CURSOR_SIZE from
  // wrapping, which is what clips the cursor at the right/bottom edges.
  assign w_cx     = CW'(w_cur_x) << LOC_SHIFT;
  assign w_cy     = CW'(w_cur_y) << LOC_SHIFT;
  assign w_cx_end = w_cx + CW'(CURSOR_SIZE);
  assign w_cy_end = w_cy + CW'(CURSOR_SIZE);

  assign w_hit = (HX_W'(w_cx) <= HX_W'(r_px)) && (HX_W'(r_px) < HX_W'(w_cx_end)) &&
                 (HY_W'(w_cy) <= HY_W'(r_py)) && (HY_W'(r_py) < HY_W'(w_cy_end));

  always_comb begin
    w_color = PIX_W'(COLOR_BG);
    if (w_hit) begin
      if (w_cur_btn[BTN_LEFT])       w_color = PIX_W'(COLOR_LEFT);
      else if (w_cur_btn[BTN_RIGHT]) w_color = PIX_W'(COLOR_RIGHT);
      else                           w_color = PIX_W'(COLOR_IDLE);
    end
  end

  // Scan counters; the running address replaces a py*H_RES+px multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px       <= '0;
      r_py       <= '0;
      r_addr_cnt <= '0;
    end else if (VGA_ready) begin
      if (w_line_end) begin
        r_px <= '0;
        if (w_frame_end) r_py <= '0;
        else             r_py <= r_py + 1'b1;
      end else begin
        r_px <= r_px + 1'b1;
      end
      if (w_frame_end) r_addr_cnt <= '0;
      else             r_addr_cnt <= r_addr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_btn <= '0;
      r_act_x   <= '0;
      r_act_y   <= '0;
    end else if (w_frame_start) begin
      r_act_btn <= w_sh_btn;
      r_act_x   <= w_sh_x;
      r_act_y   <= w_sh_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= VGA_ready;
      if (VGA_ready) begin
        r_wr_addr <= r_addr_cnt;
        r_wr_data <= w_color;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_cursor_overlay_writer.sv
// Bench for cursor_overlay_writer on a reduced 32x24 frame with 4-bit mouse
// coordinates, so that whole frames and the clipping corner stay short.
module tb_cursor_overlay_writer;

  localparam int H = 32;
  localparam int V = 24;
  localparam int N = H * V;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       VGA_ready = 1'b0;
  logic [7:0] data;
  logic [1:0] addr;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [2:0] wr_data;

  logic [7:0] reg_status = 8'h00;
  logic [7:0] reg_x = 8'h00;
  logic [7:0] reg_y = 8'h00;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  cursor_overlay_writer #(
    .H_RES       (H),
    .V_RES       (V),
    .ADDR_W      (10),
    .PIX_W       (3),
    .LOC_W       (4),
    .LOC_SHIFT   (1),
    .CURSOR_SIZE (4),
    .COLOR_BG    (0),
    .COLOR_IDLE  (6),
    .COLOR_LEFT  (4),
    .COLOR_RIGHT (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .VGA_ready (VGA_ready),
    .data      (data),
    .addr      (addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  // Register-file model: combinational read by address.
  always_comb begin
    data = 8'h00;
    case (addr)
      2'd0: data = reg_status;
      2'd1: data = reg_x;
      2'd2: data = reg_y;
      default: data = 8'h00;
    endcase
  end

  // Edges since the last reset release; the poll address is edges mod 3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  typedef struct {
    logic [7:0] st;
    logic [7:0] x;
    logic [7:0] y;
    int px_lo, px_hi, py_lo, py_hi;
    int col;
    int hits;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs one complete frame with VGA_ready held high and grades every write
  // against the expected cursor rectangle. Optionally changes reg_x after
  // pixel chg_idx (chg_idx < 0 disables).
  task automatic run_frame(input int px_lo, input int px_hi, input int py_lo,
                           input int py_hi, input int col, input int chg_idx,
                           input logic [7:0] chg_x, output int bad_addr,
                           output int bad_pix, output int hits,
                           output int last_addr);
    int px, py, exp;
    bad_addr = 0;
    bad_pix  = 0;
    hits     = 0;
    last_addr = -1;
    VGA_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(posedge clk);
      #1;
      px = i % H;
      py = i / H;
      exp = (px >= px_lo && px <= px_hi && py >= py_lo && py <= py_hi) ? col : 0;
      if (!wr_en || int'(wr_addr) != i) bad_addr++;
      if (int'(wr_data) != exp) bad_pix++;
      if (wr_data != 3'd0) hits++;
      last_addr = int'(wr_addr);
      if (i == chg_idx) reg_x = chg_x;
    end
    VGA_ready = 1'b0;
  endtask

  initial begin
    int ba, bp, ht, la;
    int seq_err, en_err, poll_err, rst_err, exp_addr;
    logic prev_ready;

    //            st     x      y     px_lo hi  py_lo hi col hits
    vecs[0] = '{8'h00, 8'd3,  8'd2,  6,  9,  4,  7, 6, 16};
    vecs[1] = '{8'h01, 8'd5,  8'd1, 10, 13,  2,  5, 4, 16};
    vecs[2] = '{8'h03, 8'd0,  8'd0,  0,  3,  0,  3, 4, 16};
    vecs[3] = '{8'h02, 8'd7,  8'd6, 14, 17, 12, 15, 2, 16};
    vecs[4] = '{8'h00, 8'd15, 8'd11, 30, 31, 22, 23, 6, 4};
    vecs[5] = '{8'h80, 8'd1,  8'd10, 2,  5, 20, 23, 6, 16};

    #12;
    check("reset_wr_en",   int'(wr_en),   0);
    check("reset_wr_addr", int'(wr_addr), 0);
    check("reset_wr_data", int'(wr_data), 0);
    check("reset_addr",    int'(addr),    0);
    rst_n = 1'b1;
    idle(2);
    check("idle_no_write", int'(wr_en), 0);

    // Right after reset, the default all-zero cursor at (0,0) in idle colour.
    run_frame(0, 3, 0, 3, 6, -1, 8'd0, ba, bp, ht, la);
    check("rst_frame_addr_seq", ba, 0);
    check("rst_frame_pixels",   bp, 0);
    check("rst_frame_last_addr", la, N - 1);

    for (int v = 0; v < 6; v++) begin
      reg_status = vecs[v].st;
      reg_x = vecs[v].x;
      reg_y = vecs[v].y;
      idle(6);
      // Snapshot frame, then the graded frame.
      run_frame(vecs[v].px_lo, vecs[v].px_hi, vecs[v].py_lo, vecs[v].py_hi,
                vecs[v].col, -1, 8'd0, ba, bp, ht, la);
      run_frame(vecs[v].px_lo, vecs[v].px_hi, vecs[v].py_lo, vecs[v].py_hi,
                vecs[v].col, -1, 8'd0, ba, bp, ht, la);
      check($sformatf("vec%0d_addr_seq", v), ba, 0);
      check($sformatf("vec%0d_pixels", v),   bp, 0);
      check($sformatf("vec%0d_hits", v),     ht, vecs[v].hits);
    end

    // Mid-frame X change: current frame keeps px 6, next frame moves to px 20.
    reg_status = 8'h00;
    reg_x = 8'd3;
    reg_y = 8'd2;
    idle(6);
    run_frame(6, 9, 4, 7, 6, 40, 8'd10, ba, bp, ht, la);
    check("midchg_cur_pixels", bp, 0);
    check("midchg_cur_hits",   ht, 16);
    run_frame(20, 23, 4, 7, 6, -1, 8'd0, ba, bp, ht, la);
    check("midchg_next_pixels", bp, 0);
    check("midchg_next_hits",   ht, 16);
    check("midchg_next_addr_seq", ba, 0);

    // Random VGA_ready with a mid-frame reset pulse.
    seq_err = 0; en_err = 0; poll_err = 0; rst_err = 0;
    exp_addr = 0;
    prev_ready = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      VGA_ready = 1'($urandom_range(0, 1));
      prev_ready = VGA_ready;
      @(posedge clk);
      #1;
      if (wr_en !== prev_ready) en_err++;
      if (wr_en) begin
        if (int'(wr_addr) != exp_addr) seq_err++;
        exp_addr = (exp_addr + 1) % N;
      end
      if (int'(addr) != edges % 3) poll_err++;
      if (c == 500) begin
        rst_n = 1'b0;
        #1;
        if (wr_en !== 1'b0 || wr_addr !== 10'd0 || wr_data !== 3'd0 || addr !== 2'd0)
          rst_err++;
        #2;
        rst_n = 1'b1;
        exp_addr = 0;
      end
    end
    check("rand_wr_en_follows_ready", en_err, 0);
    check("rand_addr_increment", seq_err, 0);
    check("rand_poll_addr_cycle", poll_err, 0);
    check("rand_mid_reset_clear", rst_err, 0);

    VGA_ready = 1'b0;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
